// File: rtl/mult_pkg.sv
// mult_pkg: shared FSM state type and default operand width for the shift-add multiplier.
package mult_pkg;
  localparam int WIDTH_DEF = 8;
  typedef enum logic [1:0] {IDLE, ADD, SHIFT, HOLD} mult_state_e;
endpackage

// File: rtl/add_sub_w.sv
// add_sub_w: (WIDTH+1)-bit adder/subtractor; with SHIFT_ADD_MULT_SIGNED_EN undefined it is add-only.
module add_sub_w #(parameter int WIDTH = 8) (
  input  logic [WIDTH:0]   a,
  input  logic [WIDTH-1:0] b,
  input  logic             sext,
  input  logic             sub,
  output logic [WIDTH:0]   y
);
`ifdef SHIFT_ADD_MULT_SIGNED_EN
  logic [WIDTH:0] bx;
  assign bx = {sext & b[WIDTH-1], b};
  assign y  = sub ? a - bx : a + bx;
`else
  logic unused_ctl;
  assign unused_ctl = sext ^ sub;
  assign y = a + {1'b0, b};
`endif
endmodule

// File: rtl/shift_add_mult_p.sv
// shift_add_mult_p: sequential shift-add multiplier, {Aval,Bval} = B * M after 2*WIDTH cycles.
// Two's-complement mode is available only when SHIFT_ADD_MULT_SIGNED_EN is defined.
module shift_add_mult_p
  import mult_pkg::*;
#(parameter int WIDTH = WIDTH_DEF) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             ClearA_LoadB,
  input  logic             Execute,
  input  logic             Signed,
  input  logic [WIDTH-1:0] Din,
  output logic [WIDTH-1:0] Aval,
  output logic [WIDTH-1:0] Bval,
  output logic             X,
  output logic             Busy,
  output logic             Done
);
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  mult_state_e state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, m_q, m_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic x_q, x_d, sgn_q, sgn_d, sgn_in;
  logic [WIDTH:0] sum;
`ifdef SHIFT_ADD_MULT_SIGNED_EN
  assign sgn_in = Signed;
`else
  logic unused_signed;
  assign unused_signed = Signed;
  assign sgn_in = 1'b0;
`endif
  // Signed multiplier bit WIDTH-1 carries negative weight, hence the final subtract
  add_sub_w #(.WIDTH(WIDTH)) u_add (
    .a({x_q, a_q}), .b(m_q), .sext(sgn_q), .sub(sgn_q && cnt_q == LAST), .y(sum)
  );
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      m_q     <= '0;
      cnt_q   <= '0;
      x_q     <= 1'b0;
      sgn_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      m_q     <= m_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      sgn_q   <= sgn_d;
    end
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = (!ClearA_LoadB && Execute) ? ADD : IDLE;
      ADD:     state_d = SHIFT;
      SHIFT:   state_d = (cnt_q == LAST) ? HOLD : ADD;
      default: state_d = Execute ? HOLD : IDLE;
    endcase
  end
  always_comb begin
    a_d   = a_q;
    b_d   = b_q;
    m_d   = m_q;
    cnt_d = cnt_q;
    x_d   = x_q;
    sgn_d = sgn_q;
    case (state_q)
      IDLE: begin
        if (ClearA_LoadB) begin
          b_d = Din;
          a_d = '0;
          x_d = 1'b0;
        end else if (Execute) begin
          m_d   = Din;
          a_d   = '0;
          x_d   = 1'b0;
          cnt_d = '0;
          sgn_d = sgn_in;
        end
      end
      ADD:   if (b_q[0]) {x_d, a_d} = sum;
      SHIFT: begin
        {x_d, a_d, b_d} = {sgn_q & x_q, x_q, a_q, b_q[WIDTH-1:1]};
        cnt_d = cnt_q + 1'b1;
      end
      default: ;
    endcase
  end
  always_comb begin
    Aval = a_q;
    Bval = b_q;
    X    = x_q;
    Busy = (state_q == ADD) || (state_q == SHIFT);
    Done = (state_q == HOLD);
  end
endmodule

// File: tb/tb_shift_add_mult_p.sv
// tb_shift_add_mult_p: vector table, hand sequences and random runs against an arithmetic product model.
module tb_shift_add_mult_p;
  localparam int W = 8;
`ifdef SHIFT_ADD_MULT_SIGNED_EN
  localparam bit SEN = 1'b1;
`else
  localparam bit SEN = 1'b0;
`endif
  logic Clk = 1'b0, Reset_n = 1'b0, ClearA_LoadB = 1'b0, Execute = 1'b0, Signed = 1'b0;
  logic [W-1:0] Din = '0, Aval, Bval;
  logic X, Busy, Done;
  int vectors = 0, miscompares = 0;

  shift_add_mult_p #(.WIDTH(W)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .ClearA_LoadB(ClearA_LoadB), .Execute(Execute),
    .Signed(Signed), .Din(Din), .Aval(Aval), .Bval(Bval), .X(X), .Busy(Busy), .Done(Done)
  );

  always #5 Clk = ~Clk;

  typedef struct {logic [7:0] b; logic [7:0] m; logic s; logic [15:0] p; logic x;} vec_t;
  vec_t tbl[5];

  function automatic logic [16:0] ref_mul(input logic [7:0] b, input logic [7:0] m, input logic s);
    int bi, mi, p;
    logic eff;
    eff = s & SEN;
    bi = eff ? int'($signed(b)) : int'(b);
    mi = eff ? int'($signed(m)) : int'(m);
    p = bi * mi;
    return {eff & (p < 0), p[15:0]};
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic do_load(input logic [7:0] v);
    @(negedge Clk);
    ClearA_LoadB = 1'b1;
    Din = v;
    @(negedge Clk);
    ClearA_LoadB = 1'b0;
    chk("load", {X, Aval, Bval}, {1'b0, 8'h00, v});
  endtask

  task automatic run_mul(input logic [7:0] din, input logic s, input bit pulse_clr,
                         output logic [15:0] p, output logic x);
    int busy_n;
    bit got;
    @(negedge Clk);
    Execute = 1'b1;
    Din = din;
    Signed = s;
    @(negedge Clk);
    Din = 8'($urandom);
    busy_n = 0;
    got = 0;
    for (int i = 0; i < 100 && !got; i++) begin
      chk("busy_done_excl", {31'd0, Busy & Done}, 0);
      if (Done) got = 1;
      else begin
        busy_n += int'(Busy);
        ClearA_LoadB = pulse_clr && busy_n == 3;
        if (ClearA_LoadB) Din = 8'hAA;
        @(negedge Clk);
      end
    end
    ClearA_LoadB = 1'b0;
    chk("done_seen", {31'd0, got}, 1);
    chk("busy_cycles", busy_n, 2 * W);
    p = {Aval, Bval};
    x = X;
    Execute = 1'b0;
    @(negedge Clk);
    chk("idle_after_release", {Busy, Done}, 0);
  endtask

  initial begin
    logic [15:0] p;
    logic x;
    logic [16:0] r;
    logic [7:0] cur_b, m;
    logic s;
    int busy_n;
    tbl[0] = '{8'hC5, 8'h07, 1'b0, 16'h0563, 1'b0};
    tbl[1] = '{8'hC5, 8'h07, 1'b1, SEN ? 16'hFE63 : 16'h0563, SEN};
    tbl[2] = '{8'h80, 8'h80, 1'b1, 16'h4000, 1'b0};
    tbl[3] = '{8'hFF, 8'hFF, 1'b0, 16'hFE01, 1'b0};
    tbl[4] = '{8'hFF, 8'h01, 1'b1, SEN ? 16'hFFFF : 16'h00FF, SEN};

    #12;
    chk("reset_state", {Aval, Bval, X, Busy, Done}, 0);
    @(negedge Clk);
    Reset_n = 1'b1;

    for (int i = 0; i < 5; i++) begin
      do_load(tbl[i].b);
      run_mul(tbl[i].m, tbl[i].s, 0, p, x);
      chk($sformatf("tbl%0d_prod", i), p, tbl[i].p);
      chk($sformatf("tbl%0d_x", i), x, tbl[i].x);
    end

    // chained multiply reuses the previous low half (0x63) as B
    do_load(8'hC5);
    run_mul(8'h07, 1'b1, 0, p, x);
    run_mul(8'h02, 1'b1, 0, p, x);
    chk("chain_prod", p, 16'h00C6);
    chk("chain_x", x, 0);

    // load wins over execute, then a still-high Execute starts later
    @(negedge Clk);
    ClearA_LoadB = 1'b1;
    Execute = 1'b1;
    Din = 8'h0B;
    @(negedge Clk);
    chk("load_wins", {Busy, Bval}, {1'b0, 8'h0B});
    ClearA_LoadB = 1'b0;
    Din = 8'h0D;
    @(negedge Clk);
    chk("exec_later", {31'd0, Busy}, 1);
    busy_n = 1;
    for (int i = 0; i < 39; i++) begin
      @(negedge Clk);
      busy_n += int'(Busy);
    end
    chk("hold40_one_mult", busy_n, 2 * W);
    chk("hold40_done", {Done, Aval, Bval}, {1'b1, 16'd143});
    Execute = 1'b0;
    @(negedge Clk);
    chk("hold40_release", {Busy, Done}, 0);

    do_load(8'h9E);
    run_mul(8'h5B, 1'b0, 1, p, x);
    chk("clr_during_busy", p, 16'(158 * 91));

    // asynchronous reset mid-multiply
    do_load(8'h5A);
    @(negedge Clk);
    Execute = 1'b1;
    Din = 8'h3C;
    repeat (5) @(negedge Clk);
    @(posedge Clk);
    #2 Reset_n = 1'b0;
    #1 chk("async_reset", {Aval, Bval, X, Busy, Done}, 0);
    Execute = 1'b0;
    @(negedge Clk);
    Reset_n = 1'b1;
    do_load(8'h5A);
    run_mul(8'h3C, 1'b1, 0, p, x);
    r = ref_mul(8'h5A, 8'h3C, 1'b1);
    chk("after_reset", {x, p}, r);

    cur_b = Bval;
    for (int i = 0; i < 16; i++) begin
      if ($urandom_range(1, 0) == 1) begin
        cur_b = 8'($urandom);
        do_load(cur_b);
      end
      m = 8'($urandom);
      s = 1'($urandom);
      r = ref_mul(cur_b, m, s);
      run_mul(m, s, 0, p, x);
      chk($sformatf("rand%0d_%h_%h_%0d", i, cur_b, m, s), {x, p}, r);
      cur_b = r[7:0];
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
